// File: rtl/flow_datapath.sv
// Register file, ALU, 256-word RAM and 16-entry stack of the flow CPU.
// All sequencing comes from the external control FSM; this block only executes one step per clock.
module flow_datapath (
  input  logic         clock,
  input  logic         resetn,
  input  logic         program_counter_increment,
  input  logic [3:0]   alu_op,
  input  logic [3:0]   alu_a_select,
  input  logic [3:0]   alu_b_select,
  input  logic         alu_a_source,
  input  logic         alu_b_source,
  input  logic [15:0]  alu_a_altern,
  input  logic [15:0]  alu_b_altern,
  input  logic [3:0]   alu_out_select,
  input  logic [1:0]   alu_load_src,
  input  logic         alu_store_to_mem,
  input  logic         alu_store_to_stk,
  input  logic [3:0]   vga_color_select,
  input  logic [3:0]   vga_coord_select,
  output logic [15:0]  alu_output,
  output logic [15:0]  current_instruction,
  output logic [15:0]  signflag,
  output logic [15:0]  zeroflag,
  output logic [15:0]  overflow,
  output logic [15:0]  errorbit,
  output logic [14:0]  vga_color,
  output logic [7:0]   vga_x,
  output logic [6:0]   vga_y,
  output logic [255:0] registers
);

  logic [15:0] regs  [16];
  logic [15:0] ram   [256];
  logic [15:0] stack [16];
  logic [4:0]  depth;

  logic [15:0] op_a, op_b;
  logic [15:0] sum, diff, neg;
  logic [31:0] a_ext, b_ext, product;
  logic        alu_ovf, alu_err;

  logic [3:0]  top_idx;
  logic        pop_empty, do_push, do_pop, stack_full;
  logic [15:0] pop_value, write_value, pc_base;
  logic        write_en;

  assign op_a = alu_a_source ? alu_a_altern : regs[alu_a_select];
  assign op_b = alu_b_source ? alu_b_altern : regs[alu_b_select];

  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign neg     = 16'd0 - op_a;
  assign a_ext   = {{16{op_a[15]}}, op_a};
  assign b_ext   = {{16{op_b[15]}}, op_b};
  assign product = a_ext * b_ext;

  always_comb begin
    alu_output = 16'd0;
    alu_ovf    = 1'b0;
    alu_err    = 1'b0;
    case (alu_op)
      4'h0: alu_output = op_a;
      4'h1: begin
        alu_output = sum;
        alu_ovf    = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
      end
      4'h2: begin
        alu_output = diff;
        alu_ovf    = (op_a[15] != op_b[15]) && (diff[15] != op_a[15]);
      end
      4'h3: alu_output = op_a & op_b;
      4'h4: alu_output = op_a | op_b;
      4'h5: alu_output = op_a ^ op_b;
      4'h6: alu_output = ~op_a;
      4'h7: alu_output = op_a << op_b[3:0];
      4'h8: alu_output = op_a >> op_b[3:0];
      4'h9: alu_output = 16'($signed(op_a) >>> op_b[3:0]);
      4'hA: begin
        // The signed product fits only if bits 31..15 are all copies of the sign.
        alu_output = product[15:0];
        alu_ovf    = (product[31:15] != {17{product[15]}});
      end
      4'hB: begin
        alu_output = neg;
        alu_ovf    = (op_a == 16'h8000);
      end
      4'hC: alu_output = op_b;
      default: alu_err = 1'b1;
    endcase
  end

  assign top_idx    = depth[3:0] - 4'd1;
  assign pop_empty  = (depth == 5'd0);
  assign stack_full = (depth == 5'd16);
  assign pop_value  = pop_empty ? 16'd0 : stack[top_idx];
  assign do_push    = alu_store_to_stk;
  assign do_pop     = (alu_load_src == 2'b11);

  always_comb begin
    write_value = 16'd0;
    case (alu_load_src)
      2'b01:   write_value = alu_output;
      2'b10:   write_value = ram[alu_output[7:0]];
      2'b11:   write_value = pop_value;
      default: write_value = 16'd0;
    endcase
  end

  assign write_en = (alu_load_src != 2'b00);
  // A jump combined with an increment lands one past the target.
  assign pc_base  = (write_en && alu_out_select == 4'd0) ? write_value : regs[0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
      overflow <= 16'd0;
      errorbit <= 16'd0;
      depth    <= 5'd0;
    end else begin
      if (write_en) begin
        regs[alu_out_select]     <= write_value;
        overflow[alu_out_select] <= (alu_load_src == 2'b01) && alu_ovf;
        errorbit[alu_out_select] <= ((alu_load_src == 2'b01) && alu_err) ||
                                    ((alu_load_src == 2'b11) && pop_empty);
      end
      if (program_counter_increment) regs[0] <= pc_base + 16'd1;
      if (do_push && do_pop && !pop_empty) depth <= depth;
      else if (do_push && !stack_full)     depth <= depth + 5'd1;
      else if (do_pop && !pop_empty)       depth <= depth - 5'd1;
    end
  end

  // Memories are deliberately left out of reset so they map onto plain RAM.
  always_ff @(posedge clock) begin
    if (alu_store_to_mem) ram[alu_output[7:0]] <= op_b;
    if (do_push) begin
      if (do_pop && !pop_empty) stack[top_idx] <= alu_output;
      else if (!stack_full)     stack[depth[3:0]] <= alu_output;
    end
  end

  assign current_instruction = ram[regs[0][7:0]];
  assign vga_color = regs[vga_color_select][14:0];
  assign vga_x     = regs[vga_coord_select][15:8];
  assign vga_y     = regs[vga_coord_select][6:0];

  always_comb begin
    signflag  = 16'd0;
    zeroflag  = 16'd0;
    registers = '0;
    for (int i = 0; i < 16; i++) begin
      signflag[i]          = regs[i][15];
      zeroflag[i]          = (regs[i] == 16'd0);
      registers[16*i +: 16] = regs[i];
    end
  end

endmodule

// File: tb/tb_flow_datapath.sv
// Directed bench for flow_datapath: each step drives one control word, clocks once and
// compares the results against hand-computed values with immediate assertions.
module tb_flow_datapath;

  logic         clock = 1'b0;
  logic         resetn;
  logic         program_counter_increment;
  logic [3:0]   alu_op, alu_a_select, alu_b_select, alu_out_select;
  logic         alu_a_source, alu_b_source;
  logic [15:0]  alu_a_altern, alu_b_altern;
  logic [1:0]   alu_load_src;
  logic         alu_store_to_mem, alu_store_to_stk;
  logic [3:0]   vga_color_select, vga_coord_select;
  logic [15:0]  alu_output, current_instruction, signflag, zeroflag, overflow, errorbit;
  logic [14:0]  vga_color;
  logic [7:0]   vga_x;
  logic [6:0]   vga_y;
  logic [255:0] registers;

  int testsRun = 0;
  int testsFailed = 0;

  flow_datapath dut (
    .clock(clock), .resetn(resetn),
    .program_counter_increment(program_counter_increment),
    .alu_op(alu_op), .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
    .alu_a_source(alu_a_source), .alu_b_source(alu_b_source),
    .alu_a_altern(alu_a_altern), .alu_b_altern(alu_b_altern),
    .alu_out_select(alu_out_select), .alu_load_src(alu_load_src),
    .alu_store_to_mem(alu_store_to_mem), .alu_store_to_stk(alu_store_to_stk),
    .vga_color_select(vga_color_select), .vga_coord_select(vga_coord_select),
    .alu_output(alu_output), .current_instruction(current_instruction),
    .signflag(signflag), .zeroflag(zeroflag), .overflow(overflow), .errorbit(errorbit),
    .vga_color(vga_color), .vga_x(vga_x), .vga_y(vga_y), .registers(registers)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] regOf(input int idx);
    return registers[16*idx +: 16];
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Drives one control word; sources are 1 for altern values, 0 for register operands.
  task automatic applyStimulus(input logic [3:0] op,
                               input logic aSrc, input logic [3:0] aSel, input logic [15:0] aAlt,
                               input logic bSrc, input logic [3:0] bSel, input logic [15:0] bAlt,
                               input logic [3:0] dst, input logic [1:0] load,
                               input logic inc, input logic mem, input logic stk);
    alu_op = op;
    alu_a_source = aSrc; alu_a_select = aSel; alu_a_altern = aAlt;
    alu_b_source = bSrc; alu_b_select = bSel; alu_b_altern = bAlt;
    alu_out_select = dst; alu_load_src = load;
    program_counter_increment = inc;
    alu_store_to_mem = mem; alu_store_to_stk = stk;
    #1;
  endtask

  task automatic clockStep();
    @(posedge clock);
    #1;
    applyStimulus(4'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    vga_color_select = 4'd0;
    vga_coord_select = 4'd0;
    applyStimulus(4'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_registers", registers, 256'd0);
    checkOutput("reset_zeroflag", zeroflag, 256'hFFFF);
    checkOutput("reset_errorbit", errorbit, 256'd0);
    checkOutput("reset_signflag", signflag, 256'd0);
    checkOutput("reset_vga_x", vga_x, 256'd0);
    resetn = 1'b1;

    applyStimulus(4'h1, 1'b0, 4'd7, 16'h0, 1'b1, 4'd0, 16'h0002, 4'd7, 2'b01, 1'b1, 1'b0, 1'b0);
    checkOutput("add_comb", alu_output, 256'h0002);
    clockStep();
    checkOutput("add_r7", regOf(7), 256'h0002);
    checkOutput("pc_inc", regOf(0), 256'h0001);

    applyStimulus(4'h0, 1'b0, 4'd7, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    clockStep();
    checkOutput("jump_inc_r0", regOf(0), 256'h0003);
    checkOutput("jump_inc_r7", regOf(7), 256'h0002);
    applyStimulus(4'h0, 1'b0, 4'd7, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    clockStep();
    checkOutput("jump_r0", regOf(0), 256'h0002);

    applyStimulus(4'h1, 1'b1, 4'd0, 16'h7FFF, 1'b1, 4'd0, 16'h0001, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0);
    clockStep();
    checkOutput("ovf_r3", regOf(3), 256'h8000);
    checkOutput("ovf_flag3", overflow[3], 256'd1);
    checkOutput("ovf_sign3", signflag[3], 256'd1);
    applyStimulus(4'h1, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 16'h0001, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0);
    clockStep();
    checkOutput("wrap_r3", regOf(3), 256'h0000);
    checkOutput("wrap_zero3", zeroflag[3], 256'd1);
    checkOutput("wrap_ovf3", overflow[3], 256'd0);

    applyStimulus(4'h2, 1'b1, 4'd0, 16'h8000, 1'b1, 4'd0, 16'h0001, 4'd6, 2'b01, 1'b0, 1'b0, 1'b0);
    clockStep();
    checkOutput("sub_r6", regOf(6), 256'h7FFF);
    checkOutput("sub_ovf6", overflow[6], 256'd1);
    applyStimulus(4'hA, 1'b1, 4'd0, 16'h0100, 1'b1, 4'd0, 16'h0100, 4'd6, 2'b01, 1'b0, 1'b0, 1'b0);
    clockStep();
    checkOutput("mul_r6", regOf(6), 256'h0000);
    checkOutput("mul_ovf6", overflow[6], 256'd1);
    applyStimulus(4'hA, 1'b1, 4'd0, 16'hFFFD, 1'b1, 4'd0, 16'h0007, 4'd6, 2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("mul_neg_comb", alu_output, 256'hFFEB);
    clockStep();
    checkOutput("mul_neg_ovf6", overflow[6], 256'd0);
    applyStimulus(4'hB, 1'b1, 4'd0, 16'h8000, 1'b0, 4'd0, 16'h0, 4'd6, 2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("neg_comb", alu_output, 256'h8000);
    clockStep();
    checkOutput("neg_ovf6", overflow[6], 256'd1);
    applyStimulus(4'h9, 1'b1, 4'd0, 16'h8000, 1'b1, 4'd0, 16'h0004, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("asr_comb", alu_output, 256'hF800);
    applyStimulus(4'h8, 1'b1, 4'd0, 16'h8000, 1'b1, 4'd0, 16'h0004, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("lsr_comb", alu_output, 256'h0800);
    applyStimulus(4'h7, 1'b1, 4'd0, 16'h0003, 1'b1, 4'd0, 16'h0012, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("shl_comb", alu_output, 256'h000C);
    applyStimulus(4'hD, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 16'h0, 4'd10, 2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("rsvd_comb", alu_output, 256'h0000);
    clockStep();
    checkOutput("rsvd_err10", errorbit[10], 256'd1);

    applyStimulus(4'h0, 1'b1, 4'd0, 16'h0005, 1'b1, 4'd0, 16'h1234, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    clockStep();
    applyStimulus(4'h0, 1'b1, 4'd0, 16'h0005, 1'b0, 4'd0, 16'h0, 4'd4, 2'b10, 1'b0, 1'b0, 1'b0);
    clockStep();
    checkOutput("load_r4", regOf(4), 256'h1234);
    applyStimulus(4'h0, 1'b1, 4'd0, 16'h0005, 1'b0, 4'd0, 16'h0, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    clockStep();
    checkOutput("instr_fetch", current_instruction, 256'h1234);

    applyStimulus(4'h0, 1'b1, 4'd0, 16'h00AA, 1'b0, 4'd0, 16'h0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    clockStep();
    applyStimulus(4'h0, 1'b1, 4'd0, 16'h00BB, 1'b0, 4'd0, 16'h0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    clockStep();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 2'b11, 1'b0, 1'b0, 1'b0);
      clockStep();
      checkOutput($sformatf("pop%0d_r5", i), regOf(5), (i == 0) ? 256'h00BB : (i == 1) ? 256'h00AA : 256'h0);
      checkOutput($sformatf("pop%0d_err5", i), errorbit[5], (i == 2) ? 256'd1 : 256'd0);
    end

    applyStimulus(4'h0, 1'b1, 4'd0, 16'h0011, 1'b0, 4'd0, 16'h0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    clockStep();
    applyStimulus(4'h0, 1'b1, 4'd0, 16'h0022, 1'b0, 4'd0, 16'h0, 4'd9, 2'b11, 1'b0, 1'b0, 1'b1);
    clockStep();
    checkOutput("pushpop_r9", regOf(9), 256'h0011);
    applyStimulus(4'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd9, 2'b11, 1'b0, 1'b0, 1'b0);
    clockStep();
    checkOutput("pushpop_top", regOf(9), 256'h0022);
    checkOutput("pushpop_err9", errorbit[9], 256'd0);

    applyStimulus(4'h0, 1'b1, 4'd0, 16'hABCD, 1'b0, 4'd0, 16'h0, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0);
    clockStep();
    vga_color_select = 4'd8;
    vga_coord_select = 4'd8;
    #1;
    checkOutput("vga_color", vga_color, 256'h2BCD);
    checkOutput("vga_x", vga_x, 256'hAB);
    checkOutput("vga_y", vga_y, 256'h4D);

    applyStimulus(4'h0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    clockStep();
    checkOutput("pc_wrap", regOf(0), 256'h0000);

    applyStimulus(4'h0, 1'b1, 4'd0, 16'h5555, 1'b0, 4'd0, 16'h0, 4'd1, 2'b01, 1'b1, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset", registers, 256'd0);
    @(posedge clock);
    #1;
    checkOutput("reset_blocks_write", regOf(1), 256'h0000);
    checkOutput("reset_clears_err", errorbit, 256'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
